opendap_swd_host: RTL
=====================

# opendap_swd_host

SWD host (initiator) that drives the serial-wire link into an OpenDAP DP. It accepts one transfer command at a time from a local controller: DP/AP read or write, TARGETSEL, or line reset. It generates SWCLK, serialises the header and write data, samples ACK and read data, and returns a single response per command. It sits in the probe/testbench side of the design, pin-to-pin with the DP's swclk/swdi/swdo.

## Interface
- `DIV`, 1: SWCLK half-period in clk cycles, ≥1.
- `N_IDLE`, 2: idle low bits driven after each transfer and after line reset, ≥2.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_linereset` in 1: 1 = line reset command; the other cmd fields are ignored.
- `cmd_ap_ndp` in 1, `cmd_r_nw` in 1, `cmd_addr` in 2 (A[3:2]), `cmd_wdata` in 32: transfer fields.
- `rsp_valid` out 1: single-cycle response pulse.
- `rsp_ack` out 3: ACK as received, bit0 = first bit.
- `rsp_rdata` out 32: read data.
- `rsp_parity_err` out 1: read data parity error.
- `swclk` out 1: link clock.
- `swdo` out 1, `swdo_en` out 1: data out and output enable.
- `swdi` in 1: data in, synchronous to clk.

## Operation
- **Reset values.** swclk=0, swdo=0, swdo_en=1, cmd_ready=1, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_parity_err=0. Phase is IDLE.
- **Command accept.** A command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` is high only in IDLE and drops the cycle after accept. The fields are latched on accept.
- **Phases.**
  - IDLE → HEADER, or → LINERESET for a line reset command.
  - HEADER → TURN_ACK → ACK, or → TGT_SKIP for TARGETSEL.
  - From ACK:
    - ACK OK and read → RDATA → TURN_RDATA → TAIL.
    - ACK OK and write → TURN_WDATA → WDATA → TAIL.
    - Any other ACK (WAIT 3'b010, FAULT 3'b100, anything else including 3'b111 no-response) → TURN_FAULT → TAIL.
  - TGT_SKIP → WDATA → TAIL.
  - LINERESET → TAIL.
  - TAIL → RESP → IDLE.
- **HEADER.** 8 bits driven in order: 1, APnDP, RnW, A2, A3, even parity of those four, 0, 1.
- **Turnaround (TURN_*).** One bit with swdo_en=0.
- **ACK.** 3 bits sampled with swdo_en=0, stored LSB-first. OK is the sequence 1,0,0 (3'b001).
- **RDATA.** 32 bits LSB-first, then a parity bit; all sampled with swdo_en=0. rsp_parity_err = parity ^ (^rdata).
- **WDATA.** 32 bits LSB-first driven, then the even parity bit.
- **TARGETSEL.** Recognised by ap_ndp=0, r_nw=0, addr=2'b11. TGT_SKIP is 5 bits undriven (turnaround + 3 ACK + turnaround), and the ACK is not sampled. Write data is then driven. rsp_ack=3'b000.
- **LINERESET.** 56 bits of 1, then TAIL. rsp_ack=0.
- **TAIL.** N_IDLE bits of swdo=0 with swdo_en=1.
- **Non-OK ACK.** No data phase. The target must have CTRL/STAT.ORUNDETECT=0; the host does not support overrun detect.
- **RESP.** rsp_valid pulses for 1 clk. rsp_rdata is 0 unless the transfer was an OK read. rsp_ack, rsp_rdata and rsp_parity_err hold their values until the next RESP.
- **Bit counter.** 6-bit bit counter, loaded at each phase entry with (phase length − 1). The phase advances when the counter reaches 0 at a rising strobe.

## Timing
- **Bit period.** One bit = 2·DIV clk cycles: swclk low for DIV cycles, then high for DIV cycles.
- **swclk when idle.** swclk is held low in IDLE and RESP, and toggles only while a command is active.
- **Driving.** swdo and swdo_en update on the clk edge at which swclk falls, and at the start of the first bit.
- **Sampling.** swdi is sampled on the clk edge at which swclk rises. This matches a DP that registers swdo on posedge swclk.
- **Transfer lengths.**
  - OK read or OK write: 46+N_IDLE bits.
  - TARGETSEL: 46+N_IDLE bits.
  - Non-OK ACK: 13+N_IDLE bits.
  - Line reset: 56+N_IDLE bits.
- **Latency.** rsp_valid asserts 1 clk after the final high phase ends. Command-accept to rsp_valid = bits·2·DIV+1 clk. cmd_ready reasserts the cycle after rsp_valid.
- **Reset mid-operation.** Asynchronous return to the reset values. No rsp_valid is issued and any partial response is discarded.
- **Back-to-back commands.** A command may be accepted in the same cycle cmd_ready rises. There is no gap beyond TAIL.

## Structure
- **Package `opendap_swd_pkg`.**
  - ACK codes ACK_OK=3'b001, ACK_WAIT=3'b010, ACK_FAULT=3'b100.
  - Phase enum and width.
  - LINE_RESET_LEN=56.
  - TARGETSEL address constant.
  - Header parity function.
- **Sub-module `opendap_swclk_gen`.** Divider producing swclk plus one-cycle `rise`/`fall` strobes; enabled only while busy, forced low when idle.

## Test plan
- **OK read.** DIV=1; read DP addr 0 against an opendap DP with DPIDR=32'hdeadbeef → header bits 1,0,1,0,0,1,0,1; rsp_ack=3'b001, rsp_rdata=32'hdeadbeef, rsp_parity_err=0; rsp_valid exactly 97 clk after accept.
- **OK write.** AP write addr 1, wdata=32'h8000_0001 → data bits LSB-first, parity bit 0; swdo_en low for exactly the 5 turnaround/ACK bits.
- **WAIT.** Responder drives ACK 0,1,0 → rsp_ack=3'b010, no data phase; rsp_valid 13+N_IDLE bits after accept; rsp_rdata=0.
- **Parity error.** Read where the responder flips the parity bit → rsp_parity_err=1, rsp_rdata still captured.
- **Line reset then TARGETSEL.**
  - Line reset → 56 ones then 2 zeros, rsp_ack=0.
  - TARGETSEL wdata=32'h0100_2927 → ACK bits undriven and ignored, data driven, rsp_ack=3'b000.
- **Reset mid-transfer.** rst asserted mid-RDATA → swclk=0, cmd_ready=1 immediately, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/opendap_swd_pkg.sv
// Shared types, constants and helpers for the OpenDAP SWD host.
// Phase lengths live here so the host FSM and any reader agree on bit counts.
package opendap_swd_pkg;

  typedef enum logic [2:0] {
    ACK_OK    = 3'b001,
    ACK_WAIT  = 3'b010,
    ACK_FAULT = 3'b100
  } ack_e;

  localparam int PHASE_W = 4;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE,
    PH_HEADER,
    PH_TURN_ACK,
    PH_ACK,
    PH_TGT_SKIP,
    PH_RDATA,
    PH_TURN_RDATA,
    PH_TURN_WDATA,
    PH_WDATA,
    PH_TURN_FAULT,
    PH_LINERESET,
    PH_TAIL,
    PH_RESP
  } phase_e;

  localparam int         BITCNT_W       = 6;
  localparam int         LINE_RESET_LEN = 56;
  localparam logic [1:0] TARGETSEL_ADDR = 2'b11;

  function automatic logic header_parity(input logic ap_ndp, input logic r_nw,
                                         input logic [1:0] addr);
    return ^{ap_ndp, r_nw, addr};
  endfunction

  // Value the bit counter is loaded with on entry to a phase (length - 1).
  function automatic logic [BITCNT_W-1:0] phase_last(input phase_e p, input int n_idle);
    case (p)
      PH_HEADER:          return BITCNT_W'(7);
      PH_ACK:             return BITCNT_W'(2);
      PH_TGT_SKIP:        return BITCNT_W'(4);
      PH_RDATA, PH_WDATA: return BITCNT_W'(32);
      PH_LINERESET:       return BITCNT_W'(LINE_RESET_LEN - 1);
      PH_TAIL:            return BITCNT_W'(n_idle - 1);
      default:            return BITCNT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/opendap_swclk_gen.sv
// SWCLK divider: low for DIV clk cycles, then high for DIV cycles, while enabled.
// rise/fall flag the clk edge at which swclk is about to change.
module opendap_swclk_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic swclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(DIV - 1));
  assign rise = wrap && !swclk;
  assign fall = wrap && swclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      swclk <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      swclk <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      swclk <= ~swclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/opendap_swd_host.sv
// SWD host: runs one DP/AP transfer, TARGETSEL or line reset per command over
// swclk/swdo/swdi and returns a single registered response.
module opendap_swd_host
  import opendap_swd_pkg::*;
#(
  parameter int DIV    = 1,
  parameter int N_IDLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_linereset,
  input  logic        cmd_ap_ndp,
  input  logic        cmd_r_nw,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_parity_err,
  output logic        swclk,
  output logic        swdo,
  output logic        swdo_en,
  input  logic        swdi
);

  phase_e                phase, next_phase;
  logic [BITCNT_W-1:0]   bitcnt;
  logic                  xfer_r_nw, xfer_tgt;
  logic [31:0]           xfer_wdata;
  logic [32:0]           sh, rd;
  logic [2:0]            ack, ack_in;
  logic                  rd_ok, tail_done;
  logic                  swclk_en, rise, fall;
  logic [7:0]            header;

  // Header in transmit order from bit 0: start, APnDP, RnW, A2, A3, parity, stop, park.
  assign header = {1'b1, 1'b0, header_parity(cmd_ap_ndp, cmd_r_nw, cmd_addr),
                   cmd_addr[1], cmd_addr[0], cmd_r_nw, cmd_ap_ndp, 1'b1};
  assign ack_in   = {swdi, ack[2:1]};
  assign swclk_en = (phase != PH_IDLE) && (phase != PH_RESP);

  opendap_swclk_gen #(.DIV(DIV)) u_swclk_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (swclk_en),
    .swclk (swclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    // NOTE: next_phase gets a default before the case so no path leaves it unassigned (no latch).
    next_phase = phase;
    case (phase)
      PH_HEADER:     next_phase = xfer_tgt ? PH_TGT_SKIP : PH_TURN_ACK;
      PH_TURN_ACK:   next_phase = PH_ACK;
      PH_ACK:        next_phase = (ack_in == ACK_OK) ?
                                  (xfer_r_nw ? PH_RDATA : PH_TURN_WDATA) : PH_TURN_FAULT;
      PH_RDATA:      next_phase = PH_TURN_RDATA;
      PH_TURN_WDATA,
      PH_TGT_SKIP:   next_phase = PH_WDATA;
      PH_TURN_RDATA,
      PH_WDATA,
      PH_TURN_FAULT,
      PH_LINERESET:  next_phase = PH_TAIL;
      default:       next_phase = phase;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
    if (rst) begin
      phase          <= PH_IDLE;
      bitcnt         <= '0;
      cmd_ready      <= 1'b1;
      xfer_r_nw      <= 1'b0;
      xfer_tgt       <= 1'b0;
      xfer_wdata     <= '0;
      sh             <= '0;
      rd             <= '0;
      ack            <= '0;
      rd_ok          <= 1'b0;
      tail_done      <= 1'b0;
      swdo           <= 1'b0;
      swdo_en        <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_ack        <= '0;
      rsp_rdata      <= '0;
      rsp_parity_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            xfer_r_nw  <= cmd_r_nw;
            xfer_wdata <= cmd_wdata;
            xfer_tgt   <= !cmd_linereset && !cmd_ap_ndp && !cmd_r_nw &&
                          (cmd_addr == TARGETSEL_ADDR);
            ack        <= '0;
            rd_ok      <= 1'b0;
            tail_done  <= 1'b0;
            // Line reset and header both open with a 1, so bit 0 is driven right away.
            swdo       <= 1'b1;
            swdo_en    <= 1'b1;
            sh         <= {26'd0, header[7:1]};
            phase      <= cmd_linereset ? PH_LINERESET : PH_HEADER;
            bitcnt     <= phase_last(cmd_linereset ? PH_LINERESET : PH_HEADER, N_IDLE);
          end
        end
        PH_RESP: begin
          rsp_valid      <= 1'b1;
          rsp_ack        <= ack;
          rsp_rdata      <= rd_ok ? rd[31:0] : 32'd0;
          rsp_parity_err <= rd_ok && (rd[32] ^ (^rd[31:0]));
          phase          <= PH_IDLE;
        end
        default: begin
          if (rise) begin
            if (phase == PH_ACK)   ack <= ack_in;
            if (phase == PH_RDATA) rd  <= {swdi, rd[32:1]};
            if (bitcnt != '0) begin
              bitcnt <= bitcnt - 1'b1;
            end else if (phase == PH_TAIL) begin
              // Last idle bit: hold until its high half ends so swclk finishes low.
              tail_done <= 1'b1;
            end else begin
              phase  <= next_phase;
              bitcnt <= phase_last(next_phase, N_IDLE);
              if (next_phase == PH_WDATA) sh    <= {^xfer_wdata, xfer_wdata};
              if (next_phase == PH_RDATA) rd_ok <= 1'b1;
            end
          end else if (fall) begin
            if (tail_done) begin
              phase <= PH_RESP;
            end else begin
              case (phase)
                PH_HEADER, PH_WDATA: begin
                  swdo    <= sh[0];
                  swdo_en <= 1'b1;
                  sh      <= {1'b0, sh[32:1]};
                end
                PH_LINERESET: begin
                  swdo    <= 1'b1;
                  swdo_en <= 1'b1;
                end
                PH_TAIL: begin
                  swdo    <= 1'b0;
                  swdo_en <= 1'b1;
                end
                default: begin
                  swdo    <= 1'b0;
                  swdo_en <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
